// File: rtl/oisc8_pkg.sv
// OISC8 shared types: move-bus address codes, instruction word layout
// and sequencer state encoding.
package oisc8_pkg;

  typedef enum logic [3:0] {
    REG0   = 4'd0,
    REG1   = 4'd1,
    REG2   = 4'd2,
    REG3   = 4'd3,
    MEMPT0 = 4'd4,
    MEMPT1 = 4'd5,
    MEM    = 4'd6,
    ALUA   = 4'd7,
    ALUB   = 4'd8,
    BRPT0  = 4'd9,
    BRPT1  = 4'd10,
    BRZ    = 4'd11,
    IOPORT = 4'd12,
    DNONE  = 4'd15
  } e_iaddr_dst;

  typedef enum logic [7:0] {
    NULL  = 8'h00,
    REG0R = 8'h01,
    REG1R = 8'h02,
    REG2R = 8'h03,
    REG3R = 8'h04,
    MEMR  = 8'h05,
    ADD   = 8'h10,
    SUB   = 8'h11,
    PC0R  = 8'h20,
    PC1R  = 8'h21
  } e_iaddr_src;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } e_seq_state;

  localparam logic [3:0] NOP_DST = 4'd15;

  typedef struct packed {
    logic       imm;
    e_iaddr_dst dst;
    e_iaddr_src src;
  } t_instr;

endpackage

// File: rtl/oisc8_fetch_seq.sv
// OISC8 instruction sequencer: F/R/E fetch pipeline, BRZ redirect,
// stall hold and terminal HALT state.
module oisc8_fetch_seq
  import oisc8_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VEC = '0,
  parameter logic [3:0]          NOP_DST   = 4'd15
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic                rom_en,
  input  logic [12:0]         rom_data,
  input  logic [7:0]          bus_data,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                stall,
  input  logic                halt_req,
  output logic                imm,
  output logic [3:0]          instr_dst,
  output logic [7:0]          instr_src,
  output logic [PC_WIDTH-1:0] pc,
  output logic                valid,
  output logic                halted
);

  localparam t_instr NOP = '{
    imm: 1'b0,
    dst: e_iaddr_dst'(NOP_DST),
    src: NULL
  };

  e_seq_state          state, state_n;
  logic [PC_WIDTH-1:0] fpc, fpc_n;
  logic                v_r, v_r_n;
  logic [PC_WIDTH-1:0] pc_r, pc_r_n;
  t_instr              ir, ir_n;
  logic                valid_e, valid_e_n;
  logic [PC_WIDTH-1:0] pc_e, pc_e_n;
  logic                br_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      fpc     <= RESET_VEC;
      v_r     <= 1'b0;
      pc_r    <= '0;
      ir      <= NOP;
      valid_e <= 1'b0;
      pc_e    <= '0;
    end else begin
      state   <= state_n;
      fpc     <= fpc_n;
      v_r     <= v_r_n;
      pc_r    <= pc_r_n;
      ir      <= ir_n;
      valid_e <= valid_e_n;
      pc_e    <= pc_e_n;
    end
  end

  assign br_take = valid_e && (ir.dst == BRZ)
                && (bus_data == 8'h00);

  // Holding every register is the stall and HALT behaviour.
  always_comb begin
    state_n   = state;
    fpc_n     = fpc;
    v_r_n     = v_r;
    pc_r_n    = pc_r;
    ir_n      = ir;
    valid_e_n = valid_e;
    pc_e_n    = pc_e;
    rom_en    = 1'b0;
    unique case (state)
      RUN: begin
        if (!stall) begin
          rom_en = 1'b1;
          if (halt_req) begin
            state_n   = HALT;
            v_r_n     = 1'b0;
            ir_n      = NOP;
            valid_e_n = 1'b0;
          end else if (br_take) begin
            fpc_n     = br_target;
            v_r_n     = 1'b0;
            ir_n      = NOP;
            valid_e_n = 1'b0;
          end else begin
            fpc_n     = fpc + 1'b1;
            v_r_n     = 1'b1;
            pc_r_n    = fpc;
            ir_n      = v_r ? t_instr'(rom_data) : NOP;
            valid_e_n = v_r;
            pc_e_n    = pc_r;
          end
        end
      end
      HALT: begin
      end
    endcase
  end

  assign rom_addr  = fpc;
  assign imm       = ir.imm;
  assign instr_dst = ir.dst;
  assign instr_src = ir.src;
  assign pc        = pc_e;
  assign valid     = valid_e;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_oisc8_fetch_seq.sv
// Directed bench for oisc8_fetch_seq with a synchronous ROM model.
// Expected values are hand-derived from the program image below.
module tb_oisc8_fetch_seq;
  import oisc8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [12:0] rom_data;
  logic [7:0]  bus_data;
  logic [15:0] br_target;
  logic        stall;
  logic        halt_req;
  logic        imm;
  logic [3:0]  instr_dst;
  logic [7:0]  instr_src;
  logic [15:0] pc;
  logic        valid;
  logic        halted;

  logic [12:0] rom [256];
  int          errors = 0;
  int          checks = 0;

  oisc8_fetch_seq dut (
    .clk       (clk),
    .rst       (rst),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .rom_data  (rom_data),
    .bus_data  (bus_data),
    .br_target (br_target),
    .stall     (stall),
    .halt_req  (halt_req),
    .imm       (imm),
    .instr_dst (instr_dst),
    .instr_src (instr_src),
    .pc        (pc),
    .valid     (valid),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rom_en) rom_data <= rom[rom_addr[7:0]];

  function automatic logic [12:0] mk(
    input logic       i,
    input logic [3:0] d,
    input logic [7:0] s
  );
    return {i, d, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mv(
    input string       tag,
    input logic [15:0] p,
    input logic [3:0]  d,
    input logic [7:0]  s
  );
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".dst"}, 32'(instr_dst), 32'(d));
    chk({tag, ".src"}, 32'(instr_src), 32'(s));
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'd0);
    chk({tag, ".dst"}, 32'(instr_dst), 32'd15);
    chk({tag, ".src"}, 32'(instr_src), 32'd0);
    chk({tag, ".imm"}, 32'(imm), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    stall     = 1'b0;
    halt_req  = 1'b0;
    bus_data  = 8'h01;
    br_target = 16'h0000;
    for (int i = 0; i < 256; i++)
      rom[i] = mk(1'b0, REG1, REG0R);
    rom[0]    = mk(1'b0, MEMPT0, ADD);
    rom[1]    = mk(1'b0, REG0, REG1R);
    rom[2]    = mk(1'b1, REG2, 8'h5A);
    rom[3]    = mk(1'b0, REG3, SUB);
    rom[4]    = mk(1'b0, BRZ, REG0R);
    rom[5]    = mk(1'b0, MEM, REG2R);
    rom[6]    = mk(1'b0, ALUA, REG0R);
    rom[7]    = mk(1'b0, ALUB, REG1R);
    rom[8]    = mk(1'b0, BRZ, REG0R);
    rom[9]    = mk(1'b0, REG2, ADD);
    rom[10]   = mk(1'b0, BRZ, REG1R);
    rom[12]   = mk(1'b0, BRZ, REG2R);
    rom[8'h40] = mk(1'b0, REG3, ADD);
    rom[8'h41] = mk(1'b0, BRZ, REG3R);
    rom[8'h50] = mk(1'b0, BRZ, ADD);
    rom[8'hFF] = mk(1'b0, REG2, SUB);

    // reset state
    repeat (3) step();
    chk_nop("rst");
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.rom_addr", 32'(rom_addr), 32'd0);

    // release: two bubbles then ROM[0]
    rst = 1'b1;
    chk_nop("rel.c1");
    step();
    chk_nop("rel.c2");
    step();
    chk_mv("rel.c3", 16'd0, MEMPT0, ADD);
    step();
    chk_mv("seq.pc1", 16'd1, REG0, REG1R);
    step();
    chk_mv("seq.pc2", 16'd2, REG2, 8'h5A);
    chk("seq.pc2.imm", 32'(imm), 32'd1);
    step();
    chk_mv("seq.pc3", 16'd3, REG3, SUB);
    step();
    chk_mv("seq.pc4", 16'd4, BRZ, REG0R);
    step();
    chk_mv("seq.pc5", 16'd5, MEM, REG2R);

    // stall for three cycles at pc 5
    stall = 1'b1;
    #1;
    chk("stl.en0", 32'(rom_en), 32'd0);
    step();
    chk_mv("stl.c2", 16'd5, MEM, REG2R);
    chk("stl.en1", 32'(rom_en), 32'd0);
    step();
    chk_mv("stl.c3", 16'd5, MEM, REG2R);
    chk("stl.en2", 32'(rom_en), 32'd0);
    stall = 1'b0;
    #1;
    chk("stl.en3", 32'(rom_en), 32'd1);
    chk_mv("stl.c4", 16'd5, MEM, REG2R);
    step();
    chk_mv("stl.pc6", 16'd6, ALUA, REG0R);
    step();
    chk_mv("stl.pc7", 16'd7, ALUB, REG1R);
    step();
    chk_mv("brz.pc8", 16'd8, BRZ, REG0R);

    // taken BRZ to 0x40
    bus_data  = 8'h00;
    br_target = 16'h0040;
    step();
    bus_data = 8'h01;
    chk_nop("brz.b1");
    chk("brz.fetch", 32'(rom_addr), 32'h40);
    step();
    chk_nop("brz.b2");
    step();
    chk_mv("brz.tgt", 16'h0040, REG3, ADD);
    step();
    chk_mv("brz.pc41", 16'h0041, BRZ, REG3R);

    // back to 8, then not-taken BRZ
    bus_data  = 8'h00;
    br_target = 16'h0008;
    step();
    bus_data = 8'h01;
    chk_nop("back.b1");
    step();
    chk_nop("back.b2");
    step();
    chk_mv("nt.pc8", 16'd8, BRZ, REG0R);
    step();
    chk_mv("nt.pc9", 16'd9, REG2, ADD);
    step();
    chk_mv("nt.pc10", 16'd10, BRZ, REG1R);
    bus_data = 8'h00;
    step();
    bus_data = 8'h01;
    chk_nop("back2.b1");
    step();
    chk_nop("back2.b2");
    step();
    chk_mv("sbr.pc8", 16'd8, BRZ, REG0R);

    // taken BRZ held by stall for two cycles
    bus_data  = 8'h00;
    br_target = 16'h0050;
    stall     = 1'b1;
    step();
    chk_mv("sbr.hold1", 16'd8, BRZ, REG0R);
    chk("sbr.fpc", 32'(rom_addr), 32'd10);
    step();
    chk_mv("sbr.hold2", 16'd8, BRZ, REG0R);
    stall = 1'b0;
    step();
    bus_data = 8'h01;
    chk_nop("sbr.b1");
    chk("sbr.fetch", 32'(rom_addr), 32'h50);
    step();
    chk_nop("sbr.b2");
    step();
    chk_mv("sbr.tgt", 16'h0050, BRZ, ADD);

    // to 12, then halt together with taken BRZ
    bus_data  = 8'h00;
    br_target = 16'd12;
    step();
    bus_data = 8'h01;
    step();
    step();
    chk_mv("hlt.pc12", 16'd12, BRZ, REG2R);
    bus_data  = 8'h00;
    br_target = 16'h0060;
    halt_req  = 1'b1;
    step();
    halt_req = 1'b0;
    bus_data = 8'h01;
    chk("hlt.halted", 32'(halted), 32'd1);
    chk_nop("hlt.bus");
    chk("hlt.en", 32'(rom_en), 32'd0);
    chk("hlt.fpc", 32'(rom_addr), 32'd14);
    for (int i = 0; i < 20; i++) begin
      stall    = i[0];
      halt_req = i[1];
      step();
      chk("hlt.stay", 32'(halted), 32'd1);
      chk("hlt.val", 32'(valid), 32'd0);
      chk("hlt.en2", 32'(rom_en), 32'd0);
    end
    stall    = 1'b0;
    halt_req = 1'b0;

    // restart, stall at pc 3, async reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rs.halted", 32'(halted), 32'd0);
    chk_nop("rs.c1");
    step();
    step();
    chk_mv("rs.c3", 16'd0, MEMPT0, ADD);
    repeat (3) step();
    chk_mv("rs.pc3", 16'd3, REG3, SUB);
    stall = 1'b1;
    step();
    chk_mv("rs.stl", 16'd3, REG3, SUB);
    #2;
    rst = 1'b0;
    #1;
    chk_nop("ar");
    chk("ar.pc", 32'(pc), 32'd0);
    chk("ar.addr", 32'(rom_addr), 32'd0);
    step();
    stall = 1'b0;
    rst   = 1'b1;
    chk_nop("ar.c1");
    step();
    chk_nop("ar.c2");
    step();
    chk_mv("ar.c3", 16'd0, MEMPT0, ADD);
    repeat (4) step();
    chk_mv("wr.pc4", 16'd4, BRZ, REG0R);

    // branch to 0xFFFF and wrap
    bus_data  = 8'h00;
    br_target = 16'hFFFF;
    step();
    bus_data = 8'h01;
    chk("wr.f0", 32'(rom_addr), 32'hFFFF);
    step();
    chk("wr.f1", 32'(rom_addr), 32'h0000);
    step();
    chk_mv("wr.ffff", 16'hFFFF, REG2, SUB);
    step();
    chk_mv("wr.zero", 16'h0000, MEMPT0, ADD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
